// File: rtl/display_pkg.sv
// Shared display constants and helpers for the 640x480@60 Hz VGA path.
// Holds the default timing, coordinate widths and game-area geometry.
package display_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned COORD_X_W = 10;
  localparam int unsigned COORD_Y_W = 9;
  localparam int unsigned RGB_W     = 24;

  // Game area: 320x220 source image, doubled on both axes.
  localparam int unsigned GAME_W     = 320;
  localparam int unsigned GAME_H     = 220;
  localparam int unsigned GAME_SCALE = 2;
  localparam int unsigned GAME_PIX_W = GAME_W * GAME_SCALE;
  localparam int unsigned GAME_PIX_H = GAME_H * GAME_SCALE;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Half-open window test: lo <= val < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/display_axis_counter.sv
// Modulo-N position counter with enable and synchronous reset.
// wrap_o flags the terminal count, i.e. the next enabled edge returns to 0.
module display_axis_counter
  import display_pkg::*;
#(
  parameter int unsigned MODULUS = H_TOTAL,
  parameter int unsigned WIDTH   = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: position counters, active-area coordinates and a
// registered output stage that keeps colour, sync and blank aligned at the DAC.
module vga_timing_gen
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = display_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = display_pkg::H_FP,
  parameter int unsigned H_SYNC   = display_pkg::H_SYNC,
  parameter int unsigned H_BP     = display_pkg::H_BP,
  parameter int unsigned V_ACTIVE = display_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = display_pkg::V_FP,
  parameter int unsigned V_SYNC   = display_pkg::V_SYNC,
  parameter int unsigned V_BP     = display_pkg::V_BP
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pix_en,
  input  logic [RGB_W-1:0]     i_rgb,
  output logic [COORD_X_W-1:0] o_x,
  output logic [COORD_Y_W-1:0] o_y,
  output logic                 o_frame_start,
  output logic [7:0]           o_vga_r,
  output logic [7:0]           o_vga_g,
  output logic [7:0]           o_vga_b,
  output logic                 o_vga_hs,
  output logic                 o_vga_vs,
  output logic                 o_vga_blank_n,
  output logic                 o_vga_sync_n
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             v_en;
  logic             active;

  assign v_en = i_pix_en && h_wrap;

  display_axis_counter #(
    .MODULUS(H_TOT),
    .WIDTH  (CNT_W)
  ) u_h_cnt (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (i_pix_en),
    .cnt_o (h_cnt),
    .wrap_o(h_wrap)
  );

  display_axis_counter #(
    .MODULUS(V_TOT),
    .WIDTH  (CNT_W)
  ) u_v_cnt (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .en_i  (v_en),
    .cnt_o (v_cnt),
    .wrap_o(v_wrap)
  );

  assign active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign o_x    = active ? h_cnt[COORD_X_W-1:0] : '0;
  assign o_y    = active ? v_cnt[COORD_Y_W-1:0] : '0;

  rgb_t rgb_q, rgb_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic blank_n_q, blank_n_d;
  logic frame_start_q, frame_start_d;

  // Output stage samples the current position, so it lags o_x/o_y by one enable.
  always_comb begin
    rgb_d         = rgb_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    frame_start_d = i_pix_en && h_wrap && v_wrap;
    if (i_pix_en) begin
      rgb_d     = active ? rgb_t'(i_rgb) : '0;
      hs_d      = !in_window(h_cnt, HS_LO, HS_HI);
      vs_d      = !in_window(v_cnt, VS_LO, VS_HI);
      blank_n_d = active;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_vga_r       = rgb_q.r;
  assign o_vga_g       = rgb_q.g;
  assign o_vga_b       = rgb_q.b;
  assign o_vga_hs      = hs_q;
  assign o_vga_vs      = vs_q;
  assign o_vga_blank_n = blank_n_q;
  assign o_frame_start = frame_start_q;
  assign o_vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing, reduced-size instance
// (25x15 total) so vertical and frame behaviour fit in a short run.
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end \
  end

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic [23:0] d_rgb, s_rgb;
  logic [9:0]  d_x, s_x;
  logic [8:0]  d_y, s_y;
  logic        d_fs, s_fs;
  logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;
  logic        d_hs, d_vs, d_bn, d_sn, s_hs, s_vs, s_bn, s_sn;

  assign d_rgb = {d_y[7:0], d_x[7:0], 8'h5A};
  assign s_rgb = {s_y[7:0], s_x[7:0], 8'h5A};

  vga_timing_gen dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pix_en     (pix_en),
    .i_rgb        (d_rgb),
    .o_x          (d_x),
    .o_y          (d_y),
    .o_frame_start(d_fs),
    .o_vga_r      (d_r),
    .o_vga_g      (d_g),
    .o_vga_b      (d_b),
    .o_vga_hs     (d_hs),
    .o_vga_vs     (d_vs),
    .o_vga_blank_n(d_bn),
    .o_vga_sync_n (d_sn)
  );

  // Small timing: H 16/2/4/3 (hs low at h 18..21), V 8/2/2/3 (vs low at v 10..11).
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pix_en     (pix_en),
    .i_rgb        (s_rgb),
    .o_x          (s_x),
    .o_y          (s_y),
    .o_frame_start(s_fs),
    .o_vga_r      (s_r),
    .o_vga_g      (s_g),
    .o_vga_b      (s_b),
    .o_vga_hs     (s_hs),
    .o_vga_vs     (s_vs),
    .o_vga_blank_n(s_bn),
    .o_vga_sync_n (s_sn)
  );

  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic chk_wait(input string tag, input logic seen);
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $error("FAIL %s: wait expired without seeing the event", tag);
    end
  endtask

  initial begin
    int falls, low_cnt, fall1, fall2, n, vs_low, hs_low;
    logic hs_prev, found;

    // Reset with pixel enable high
    rst = 1'b1;
    pix_en = 1'b1;
    repeat (3) step(1'b1);
    total++;
    if ({d_x, d_y, d_hs, d_vs, d_bn, d_r, d_g, d_b, d_fs, d_sn} !==
        {10'd0, 9'd0, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0}) begin
      bad++;
      $error("FAIL reset_state x=%0h y=%0h hs=%b vs=%b bn=%b rgb=%0h fs=%b sn=%b",
             d_x, d_y, d_hs, d_vs, d_bn, {d_r, d_g, d_b}, d_fs, d_sn);
    end
    `CHK("rst_x", d_x, 10'd0)
    `CHK("rst_y", d_y, 9'd0)
    `CHK("rst_hs", d_hs, 1'b1)
    `CHK("rst_vs", d_vs, 1'b1)
    `CHK("rst_blank_n", d_bn, 1'b0)
    `CHK("rst_rgb", {d_r, d_g, d_b}, 24'h000000)
    `CHK("rst_frame_start", d_fs, 1'b0)
    `CHK("sync_n", d_sn, 1'b0)
    `CHK("rst_small_x", s_x, 10'd0)

    rst = 1'b0;
    step(1'b1);
    `CHK("first_x", d_x, 10'd1)
    `CHK("first_y", d_y, 9'd0)
    `CHK("first_blank_n", d_bn, 1'b1)
    `CHK("first_rgb", {d_r, d_g, d_b}, 24'h00005A)

    // Freeze at x=300
    run(299);
    `CHK("x300", d_x, 10'd300)
    `CHK("x300_rgb", {d_r, d_g, d_b}, 24'h002B5A)
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      `CHK("hold_x", d_x, 10'd300)
    end
    `CHK("hold_rgb", {d_r, d_g, d_b}, 24'h002B5A)
    `CHK("hold_blank_n", d_bn, 1'b1)
    `CHK("hold_hs", d_hs, 1'b1)
    step(1'b1);
    `CHK("resume_x", d_x, 10'd301)
    `CHK("resume_rgb", {d_r, d_g, d_b}, 24'h002C5A)

    // End of active line and hs window edges
    run(338);
    `CHK("x639", d_x, 10'd639)
    `CHK("x639_rgb", {d_r, d_g, d_b}, 24'h007E5A)
    step(1'b1);
    `CHK("h640_x", d_x, 10'd0)
    `CHK("last_px_rgb", {d_r, d_g, d_b}, 24'h007F5A)
    `CHK("last_px_blank_n", d_bn, 1'b1)
    step(1'b1);
    `CHK("blank_rgb", {d_r, d_g, d_b}, 24'h000000)
    `CHK("blank_blank_n", d_bn, 1'b0)
    run(15);
    `CHK("hs_h656", d_hs, 1'b1)
    step(1'b1);
    `CHK("hs_h657", d_hs, 1'b0)
    run(95);
    `CHK("hs_h752", d_hs, 1'b0)
    step(1'b1);
    `CHK("hs_h753", d_hs, 1'b1)

    // Half-rate enable: hs pulse width and period in clocks
    falls = 0; low_cnt = 0; fall1 = 0; fall2 = 0;
    hs_prev = d_hs;
    for (int k = 0; k < 5000 && falls < 2; k++) begin
      step(logic'(k % 2));
      if (hs_prev && !d_hs) begin
        falls++;
        if (falls == 1) fall1 = k;
        else fall2 = k;
      end
      if (falls == 1 && !d_hs) low_cnt++;
      hs_prev = d_hs;
    end
    `CHK("hs_falls_seen", falls, 2)
    `CHK("hs_low_clks", low_cnt, 192)
    `CHK("hs_period_clks", fall2 - fall1, 1600)

    // Frame timing on the small instance
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b1);
      found = s_fs;
    end
    chk_wait("fs_first_seen", found);
    n = 0; vs_low = 0; hs_low = 0; found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b1);
      n++;
      found = s_fs;
      if (!found && !s_vs) vs_low++;
      if (!found && !s_hs) hs_low++;
    end
    chk_wait("fs_second_seen", found);
    `CHK("frame_enables", n, 375)
    `CHK("vs_low_enables", vs_low, 50)
    `CHK("hs_low_per_frame", hs_low, 60)
    step(1'b1);
    `CHK("fs_width", s_fs, 1'b0)

    // Last visible pixel of the small frame
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1);
      found = (s_x == 10'd15) && (s_y == 9'd7);
    end
    chk_wait("corner_seen", found);
    step(1'b1);
    `CHK("corner_rgb", {s_r, s_g, s_b}, 24'h070F5A)
    `CHK("corner_blank_n", s_bn, 1'b1)
    step(1'b1);
    `CHK("after_corner_rgb", {s_r, s_g, s_b}, 24'h000000)
    `CHK("after_corner_blank_n", s_bn, 1'b0)

    // Mid-frame reset while both syncs are low
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1);
      found = !s_hs && !s_vs;
    end
    chk_wait("sync_low_seen", found);
    rst = 1'b1;
    step(1'b1);
    `CHK("mrst_hs", s_hs, 1'b1)
    `CHK("mrst_vs", s_vs, 1'b1)
    `CHK("mrst_x", s_x, 10'd0)
    `CHK("mrst_y", s_y, 9'd0)
    `CHK("mrst_fs", s_fs, 1'b0)
    `CHK("mrst_blank_n", s_bn, 1'b0)
    `CHK("mrst_full_hs", d_hs, 1'b1)
    rst = 1'b0;
    step(1'b1);
    `CHK("mrst_resume_x", s_x, 10'd1)
    `CHK("mrst_resume_fs", s_fs, 1'b0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
